// File: rtl/spw_fct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spw_fct_pkg (package)
// Description : SpaceWire flow-control constants and FSM state encodings.
//               The RX credit manager and the TX FCT counter both use them.
// Contents    : c_FCT_SIZE   - N-chars granted by one FCT
//               c_MAX_CREDIT - largest outstanding credit (7 FCTs)
//               c_CREDIT_W   - width of a credit counter (0..56)
//               c_ST_*       - 3-bit FSM state codes
// Revision    : 1.0 - initial release
// ============================================================================
package spw_fct_pkg;

    localparam int c_FCT_SIZE   = 8;
    localparam int c_MAX_CREDIT = 56;
    localparam int c_CREDIT_W   = 6;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_REQ    = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_ERROR  = 3'd3;

endpackage
`default_nettype wire

// File: rtl/rx_fct_credit.sv
`default_nettype none
// ============================================================================
// Module      : rx_fct_credit
// Description : Receive-side SpaceWire flow-control credit manager. Asks the
//               TX encoder for an FCT whenever the RX FIFO can take 8 more
//               N-chars beyond the credit already granted, tracks outstanding
//               credit, and flags a sticky credit error on overrun.
// Ports       : pclk_rx      - clock, rising edge
//               rst_rx       - synchronous active-high reset
//               enable_rx    - link Run state; low clears synchronously
//               fifo_free    - free RX FIFO entries (0..64)
//               got_nchar    - pulse: one N-char received
//               fct_ack      - pulse: TX has sent the requested FCT
//               fct_req      - request one FCT, held until fct_ack
//               credit_out   - N-chars still allowed to arrive (0..56)
//               credit_error - sticky: N-char arrived with no credit
// Revision    : 1.0 - initial release
// ============================================================================
module rx_fct_credit
    import spw_fct_pkg::*;
#(
    parameter int FCT_SIZE   = c_FCT_SIZE,
    parameter int MAX_CREDIT = c_MAX_CREDIT,
    parameter int FREE_W     = 7
) (
    input  logic                  pclk_rx,
    input  logic                  rst_rx,
    input  logic                  enable_rx,
    input  logic [FREE_W-1:0]     fifo_free,
    input  logic                  got_nchar,
    input  logic                  fct_ack,
    output logic                  fct_req,
    output logic [c_CREDIT_W-1:0] credit_out,
    output logic                  credit_error
);

    localparam logic [c_CREDIT_W-1:0] c_GRANT       = c_CREDIT_W'(FCT_SIZE);
    localparam logic [c_CREDIT_W-1:0] c_GRANT_LESS1 = c_CREDIT_W'(FCT_SIZE - 1);
    localparam logic [c_CREDIT_W-1:0] c_ONE         = c_CREDIT_W'(1);
    localparam logic [c_CREDIT_W-1:0] c_REQ_LIMIT   = c_CREDIT_W'(MAX_CREDIT - FCT_SIZE);
    localparam logic [FREE_W-1:0]     c_GRANT_FREE  = FREE_W'(FCT_SIZE);

    logic [2:0]            r_state;
    logic [c_CREDIT_W-1:0] r_credit;
    logic                  r_error;
    logic                  r_fct_req;

    logic [2:0]            w_state_nxt;
    logic [c_CREDIT_W-1:0] w_credit_nxt;
    logic                  w_error_nxt;
    logic                  w_ack_taken;
    logic                  w_room;

    // Widen credit to the FIFO width so credit+8 (up to 64) never truncates.
    assign w_room = (fifo_free >= (FREE_W'(r_credit) + c_GRANT_FREE)) &&
                    (r_credit <= c_REQ_LIMIT);

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_error_nxt  = r_error;
        w_ack_taken  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_room) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (fct_ack) begin
                    w_ack_taken = 1'b1;
                    w_state_nxt = c_ST_SETTLE;
                end
            end
            // One dead cycle so fifo_free catches up with in-flight writes
            // before the room check runs again.
            c_ST_SETTLE: w_state_nxt = c_ST_IDLE;
            c_ST_ERROR:  w_state_nxt = c_ST_ERROR;
            default:     w_state_nxt = c_ST_IDLE;
        endcase

        // Credit accounting is frozen once in ERROR. A grant on the same edge
        // as an N-char covers that N-char, so credit 0 plus both is not an
        // overrun.
        if (r_state != c_ST_ERROR) begin
            case ({w_ack_taken, got_nchar})
                2'b10: w_credit_nxt = r_credit + c_GRANT;
                2'b11: w_credit_nxt = r_credit + c_GRANT_LESS1;
                2'b01: begin
                    if (r_credit != '0) begin
                        w_credit_nxt = r_credit - c_ONE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = c_ST_ERROR;
                    end
                end
                default: w_credit_nxt = r_credit;
            endcase
        end
    end

    always_ff @(posedge pclk_rx) begin
        if (rst_rx || !enable_rx) begin
            r_state   <= c_ST_IDLE;
            r_credit  <= '0;
            r_error   <= 1'b0;
            r_fct_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_credit  <= w_credit_nxt;
            r_error   <= w_error_nxt;
            r_fct_req <= (w_state_nxt == c_ST_REQ);
        end
    end

    assign fct_req      = r_fct_req;
    assign credit_out   = r_credit;
    assign credit_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_rx_fct_credit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_fct_credit
// Description : Directed self-checking bench for rx_fct_credit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_fct_credit;

    logic       pclk_rx = 1'b0;
    logic       rst_rx = 1'b1;
    logic       enable_rx = 1'b1;
    logic [6:0] fifo_free = 7'd64;
    logic       got_nchar = 1'b0;
    logic       fct_ack = 1'b0;
    logic       fct_req;
    logic [5:0] credit_out;
    logic       credit_error;

    int r_checks = 0;
    int r_failures = 0;

    rx_fct_credit u_dut (
        .pclk_rx     (pclk_rx),
        .rst_rx      (rst_rx),
        .enable_rx   (enable_rx),
        .fifo_free   (fifo_free),
        .got_nchar   (got_nchar),
        .fct_ack     (fct_ack),
        .fct_req     (fct_req),
        .credit_out  (credit_out),
        .credit_error(credit_error)
    );

    always #5 pclk_rx = ~pclk_rx;

    task automatic chk(input string tag, input int obs, input int exp);
        r_checks++;
        if (obs != exp) begin
            r_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs set after this return are seen next edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge pclk_rx);
            #1;
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!fct_req && n < 20) begin
            step();
            n++;
        end
        chk(tag, int'(fct_req), 1);
    endtask

    task automatic pulse_ack();
        fct_ack = 1'b1;
        step();
        fct_ack = 1'b0;
    endtask

    initial begin
        // ---- Test 1: reset, then seven FCTs up to full credit -------------
        step(2);
        chk("rst_req", int'(fct_req), 0);
        chk("rst_credit", int'(credit_out), 0);
        chk("rst_err", int'(credit_error), 0);
        rst_rx = 1'b0;
        step();
        chk("t1_req_latency", int'(fct_req), 1);
        for (int i = 0; i < 7; i++) begin
            wait_req("t1_req_rise");
            step(2);
            chk("t1_req_held", int'(fct_req), 1);
            pulse_ack();
            chk("t1_credit", int'(credit_out), 8 * (i + 1));
            chk("t1_req_drop", int'(fct_req), 0);
            if (i < 6) begin
                // ack edge -> SETTLE -> IDLE -> REQ
                step();
                chk("t1_settle", int'(fct_req), 0);
                step();
                chk("t1_spacing", int'(fct_req), 1);
            end
        end
        step(10);
        chk("t1_full_no_req", int'(fct_req), 0);
        chk("t1_full_credit", int'(credit_out), 56);

        // ---- Test 2: nine N-chars from 56, then room restored -------------
        fifo_free = 7'd0;
        got_nchar = 1'b1;
        step(9);
        got_nchar = 1'b0;
        chk("t2_credit47", int'(credit_out), 47);
        chk("t2_no_req", int'(fct_req), 0);
        chk("t2_no_err", int'(credit_error), 0);
        fifo_free = 7'd54;
        step(2);
        chk("t2_free54_no_req", int'(fct_req), 0);
        fifo_free = 7'd55;
        step();
        chk("t2_free55_req", int'(fct_req), 1);

        // ---- Test 3: overrun at zero credit --------------------------------
        enable_rx = 1'b0;
        step();
        chk("t3_clear_credit", int'(credit_out), 0);
        chk("t3_clear_req", int'(fct_req), 0);
        enable_rx = 1'b1;
        fifo_free = 7'd0;
        step();
        got_nchar = 1'b1;
        step();
        got_nchar = 1'b0;
        chk("t3_err_set", int'(credit_error), 1);
        chk("t3_err_credit", int'(credit_out), 0);
        chk("t3_err_req", int'(fct_req), 0);
        fifo_free = 7'd64;
        step(3);
        pulse_ack();
        chk("t3_err_sticky", int'(credit_error), 1);
        chk("t3_err_frozen", int'(credit_out), 0);
        chk("t3_err_no_req", int'(fct_req), 0);
        enable_rx = 1'b0;
        step();
        enable_rx = 1'b1;
        chk("t3_err_cleared", int'(credit_error), 0);
        chk("t3_credit_cleared", int'(credit_out), 0);

        // ---- Test 4: ack and N-char on the same edge at zero credit -------
        wait_req("t4_req");
        fct_ack = 1'b1;
        got_nchar = 1'b1;
        step();
        fct_ack = 1'b0;
        got_nchar = 1'b0;
        chk("t4_credit7", int'(credit_out), 7);
        chk("t4_no_err", int'(credit_error), 0);
        chk("t4_req_drop", int'(fct_req), 0);

        // ---- Test 5: room boundary at credit 8 -----------------------------
        enable_rx = 1'b0;
        step();
        enable_rx = 1'b1;
        wait_req("t5_req");
        pulse_ack();
        chk("t5_credit8", int'(credit_out), 8);
        fifo_free = 7'd15;
        step(4);
        chk("t5_free15_no_req", int'(fct_req), 0);
        fifo_free = 7'd16;
        step();
        chk("t5_free16_req", int'(fct_req), 1);

        // ---- Test 6: reset mid-request drops it ----------------------------
        rst_rx = 1'b1;
        step();
        chk("t6_rst_req", int'(fct_req), 0);
        chk("t6_rst_credit", int'(credit_out), 0);
        rst_rx = 1'b0;
        fifo_free = 7'd0;
        pulse_ack();
        step();
        chk("t6_ack_ignored", int'(credit_out), 0);
        chk("t6_no_req", int'(fct_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
